// File: rtl/gray_pkg.sv
// gray_pkg
// Shared definitions for the grey-to-RGB path: IEEE-754 single-precision
// field widths, the 8-bit scale constant, controller state encodings and
// the input classification used by the conversion datapath.
package gray_pkg;

  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_FRAC_W = 23;
  localparam int unsigned FP_BIAS   = 127;

  // Full-scale value for the default 8-bit channel (2^8 - 1).
  localparam int unsigned SCALE_255 = 255;

  // Controller states (3-bit encodings kept stable for existing users).
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  // Input classes, decided once at unpack time.
  //   ZERO   : +/-0 or positive denormal
  //   NEG    : any negative value with nonzero magnitude (including -Inf)
  //   NAN    : exponent all ones, fraction nonzero
  //   INF    : +Inf
  //   GE1    : finite, positive, >= 1.0
  //   NORMAL : finite, positive, normal and < 1.0
  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    NEG    = 3'd1,
    NAN    = 3'd2,
    INF    = 3'd3,
    GE1    = 3'd4,
    NORMAL = 3'd5
  } fp_class_t;

endpackage

// File: rtl/gray_to_rgb_converter_fp_unit_to_uint.sv
// fp_unit_to_uint
// Converts a normalised single-precision grey level in [0.0, 1.0] to an
// OUT_W-bit unsigned integer: value * (2^OUT_W - 1), rounded half-up and
// saturated, with a clip flag for inputs outside [0.0, 1.0] or NaN.
//
// Stages:
//   unpack_en : classify din, capture exponent and mantissa
//   mul_en    : capture mantissa * full scale
//   shift     : combinational round/shift/saturate from the captured
//               product; the caller registers res/res_clip
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   unpack_en   load classification/exponent/mantissa from din
//   mul_en      load product register
//   din         IEEE-754 single word
//   res         converted channel value (combinational from registers)
//   res_clip    input was out of range or NaN (combinational)
module fp_unit_to_uint
  import gray_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             unpack_en,
  input  logic             mul_en,
  input  logic [31:0]      din,
  output logic [OUT_W-1:0] res,
  output logic             res_clip
);

  localparam int unsigned MANT_W = FP_FRAC_W + 1;
  localparam int unsigned PROD_W = MANT_W + OUT_W;
  localparam int unsigned RND_W  = PROD_W + 1;
  localparam int unsigned SH_W   = FP_EXP_W + 1;

  // All-ones is 2^OUT_W - 1: both the scale factor and the saturation value.
  localparam logic [OUT_W-1:0]    FULL_SCALE = '1;
  // value = mant * 2^(exp - BIAS - FRAC_W), so the product is shifted right
  // by (BIAS + FRAC_W) - exp.
  localparam logic [SH_W-1:0]     SH_BASE    = SH_W'(FP_BIAS + FP_FRAC_W);
  localparam logic [FP_EXP_W-1:0] EXP_ONE    = FP_EXP_W'(FP_BIAS);

  logic                 din_s;
  logic [FP_EXP_W-1:0]  din_e;
  logic [FP_FRAC_W-1:0] din_f;

  assign {din_s, din_e, din_f} = din;

  // ---------------------------------------------------------------------
  // Classification (priority order matters: NaN beats sign, sign beats
  // zero/denormal so a negative denormal clips).
  // ---------------------------------------------------------------------
  fp_class_t cls_d;

  always_comb begin
    cls_d = NORMAL;
    if (din_e == '1 && din_f != '0)
      cls_d = NAN;
    else if (din_e == '1 && !din_s)
      cls_d = INF;
    else if (din_s && (din_e != '0 || din_f != '0))
      cls_d = NEG;
    else if (din_e == '0)
      cls_d = ZERO;
    else if (din_e >= EXP_ONE)
      cls_d = GE1;
  end

  // ---------------------------------------------------------------------
  // Unpack and multiply registers
  // ---------------------------------------------------------------------
  fp_class_t           cls_q;
  logic [FP_EXP_W-1:0] exp_q;
  logic [MANT_W-1:0]   mant_q;
  logic                exact_one_q;
  logic [PROD_W-1:0]   prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q       <= ZERO;
      exp_q       <= '0;
      mant_q      <= '0;
      exact_one_q <= 1'b0;
      prod_q      <= '0;
    end else begin
      if (unpack_en) begin
        cls_q       <= cls_d;
        exp_q       <= din_e;
        mant_q      <= (din_e == '0) ? '0 : {1'b1, din_f};
        // Only exactly 1.0 saturates without clipping.
        exact_one_q <= (din_e == EXP_ONE) && (din_f == '0);
      end
      if (mul_en) begin
        prod_q <= PROD_W'(mant_q) * PROD_W'(FULL_SCALE);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Round half-up, shift, saturate
  // ---------------------------------------------------------------------
  logic [SH_W-1:0]  sh;
  logic [RND_W-1:0] rounded;
  logic [RND_W-1:0] shifted;

  always_comb begin
    sh      = SH_BASE - {1'b0, exp_q};
    rounded = '0;
    shifted = '0;
    // Shifts wider than the product always round to zero; skipping them
    // also keeps the rounding bit inside the RND_W-bit adder.
    if (sh <= SH_W'(PROD_W)) begin
      rounded = {1'b0, prod_q} + (RND_W'(1) << (sh - SH_W'(1)));
      shifted = rounded >> sh;
    end
  end

  always_comb begin
    res      = '0;
    res_clip = 1'b0;
    case (cls_q)
      NAN: begin
        res_clip = 1'b1;
      end
      INF: begin
        res      = '1;
        res_clip = 1'b1;
      end
      NEG: begin
        res_clip = 1'b1;
      end
      ZERO: begin
        res      = '0;
      end
      GE1: begin
        res      = '1;
        res_clip = !exact_one_q;
      end
      default: begin
        // Values below 1.0 cannot exceed full scale; the clamp is a guard.
        if (shifted > RND_W'(FULL_SCALE))
          res = '1;
        else
          res = shifted[OUT_W-1:0];
      end
    endcase
  end

endmodule

// File: rtl/gray_to_rgb_converter.sv
// gray_to_rgb_converter
// Converts a normalised single-precision grey level to an 8-bit (OUT_W)
// integer and drives it on all three colour channels. Multi-cycle FSM with
// valid/ready on both sides and a one-entry output holding register.
// Latency is three edges from acceptance to out_valid; a new input can be
// accepted every five cycles at best.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   GRAY_IN is valid
//   in_ready   block can accept an input (idle only)
//   GRAY_IN    IEEE-754 single grey level
//   out_valid  R/G/B/clip hold a result
//   out_ready  consumer accepts the result
//   R, G, B    colour channels (all equal)
//   clip       input was outside [0.0, 1.0] or was NaN
module gray_to_rgb_converter
  import gray_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      GRAY_IN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] R,
  output logic [OUT_W-1:0] G,
  output logic [OUT_W-1:0] B,
  output logic             clip
);

  logic [2:0]       state;
  logic [31:0]      gray_q;
  logic [OUT_W-1:0] pix_q;
  logic [OUT_W-1:0] res;
  logic             res_clip;

  assign in_ready = (state == S_IDLE);

  fp_unit_to_uint #(
    .OUT_W(OUT_W)
  ) u_fp_unit_to_uint (
    .clk      (clk),
    .rst      (rst),
    .unpack_en(state == S_UNPACK),
    .mul_en   (state == S_MUL),
    .din      (gray_q),
    .res      (res),
    .res_clip (res_clip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gray_q    <= '0;
      pix_q     <= '0;
      clip      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            gray_q <= GRAY_IN;
            state  <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          state <= S_MUL;
        end
        S_MUL: begin
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          pix_q     <= res;
          clip      <= res_clip;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          // Result stays on R/G/B/clip after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign R = pix_q;
  assign G = pix_q;
  assign B = pix_q;

endmodule

// File: tb/tb_gray_to_rgb_converter.sv
// tb_gray_to_rgb_converter
// Directed checks of gray_to_rgb_converter: reset state, conversion of
// in-range and out-of-range inputs, backpressure, mid-operation reset and a
// stream of random in-range values against a real-arithmetic model.
module tb_gray_to_rgb_converter;
  import gray_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] GRAY_IN;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        clip;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int acc_cyc;
  int prev_acc;
  int lat;
  bit busy_ready;

  gray_to_rgb_converter #(
    .OUT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .GRAY_IN  (GRAY_IN),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R        (R),
    .G        (G),
    .B        (B),
    .clip     (clip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present x, wait for acceptance, then wait (bounded) for out_valid.
  task automatic send_and_wait(input string tag, input logic [31:0] x, input bit hold);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    GRAY_IN   = x;
    in_valid  = 1'b1;
    out_ready = !hold;
    tick();
    acc_cyc    = cyc;
    in_valid   = 1'b0;
    lat        = 0;
    busy_ready = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) busy_ready = 1'b1;
      tick();
      lat++;
    end
    if (in_ready) busy_ready = 1'b1;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] x,
                         input logic [7:0] exp_v, input logic exp_clip);
    send_and_wait(tag, x, 1'b0);
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_busy"}, {31'd0, busy_ready}, 32'd0);
    check({tag, "_rgb"}, {8'd0, R, G, B}, {8'd0, exp_v, exp_v, exp_v});
    check({tag, "_clip"}, {31'd0, clip}, {31'd0, exp_clip});
    tick();
    check({tag, "_done"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e;
    logic [31:0] f;
    logic [31:0] x;
    real r;
    int exp_v;

    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    GRAY_IN   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {5'd0, out_valid, in_ready, clip, R, G, B}, {5'd0, 3'b010, 24'd0});
    rst = 1'b0;
    tick();

    // In-range values
    run_vec("half",    32'h3F000000, 8'd128, 1'b0);
    run_vec("one",     32'h3F800000, 8'd255, 1'b0);
    run_vec("p2",      32'h3E4CCCCD, 8'd51,  1'b0);
    run_vec("lsb",     32'h3B808081, 8'd1,   1'b0);
    run_vec("zero",    32'h00000000, 8'd0,   1'b0);
    // Out-of-range and special values
    run_vec("above1",  32'h3F800001, 8'd255, 1'b1);
    run_vec("pinf",    32'h7F800000, 8'd255, 1'b1);
    run_vec("nan",     32'h7FC00000, 8'd0,   1'b1);
    run_vec("mhalf",   32'hBF000000, 8'd0,   1'b1);
    run_vec("one_b",   32'h3F800000, 8'd255, 1'b0);
    run_vec("mzero",   32'h80000000, 8'd0,   1'b0);
    run_vec("mdenorm", 32'h80000001, 8'd0,   1'b1);
    run_vec("ninf",    32'hFF800000, 8'd0,   1'b1);

    // Backpressure: result held, input ignored while busy
    send_and_wait("bp", 32'h3E4CCCCD, 1'b1);
    check("bp_lat", lat, 32'd3);
    for (int i = 0; i < 10; i++) begin
      GRAY_IN  = 32'h3F800000;
      in_valid = 1'b1;
      tick();
      check("bp_hold", {5'd0, out_valid, in_ready, clip, R, G, B},
            {5'd0, 3'b100, 8'd51, 8'd51, 8'd51});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    check("bp_keep", {24'd0, R}, 32'd51);
    run_vec("bp_next", 32'h3F800000, 8'd255, 1'b0);

    // Reset while in the multiply stage
    GRAY_IN   = 32'h3F000000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid", {5'd0, out_valid, in_ready, clip, R, G, B}, {5'd0, 3'b010, 24'd0});
    #2;
    rst = 1'b0;
    repeat (6) tick();
    check("rst_quiet", {30'd0, out_valid, in_ready}, 32'd1);
    run_vec("post_rst", 32'h3F000000, 8'd128, 1'b0);

    // Random stream of in-range values, full-rate consumer
    prev_acc = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 25 == 24) begin
        x = 32'h3F800000;
        r = 1.0;
      end else begin
        e = $urandom_range(110, 126);
        f = $urandom;
        x = {1'b0, e[7:0], f[22:0]};
        r = $bitstoreal({1'b0, 11'(e + 896), f[22:0], 29'd0});
      end
      exp_v = int'($floor(r * real'(SCALE_255) + 0.5));
      send_and_wait("rnd", x, 1'b0);
      check("rnd_lat", lat, 32'd3);
      check("rnd_rgb", {8'd0, R, G, B}, {8'd0, exp_v[7:0], exp_v[7:0], exp_v[7:0]});
      check("rnd_clip", {31'd0, clip}, 32'd0);
      if (i > 0) check("rnd_ii", acc_cyc - prev_acc, 32'd5);
      prev_acc = acc_cyc;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
